// File: rtl/fnd_state_scanner_if.sv
// Pin bundle between the PWM FSM/timer side and the FND scanner.
// The master drives state/timer inputs and observes the display outputs.
interface fnd_state_scanner_if #(
  parameter int NUM_DIGITS = 4,
  parameter int STATE_W    = 3,
  parameter int TIME_W     = 7
);
  logic [STATE_W-1:0]    i_pwm_state;
  logic [TIME_W-1:0]     i_timer_val;
  logic                  i_timer_load;
  logic [NUM_DIGITS-1:0] o_fnd_com;
  logic [7:0]            o_fnd_seg;
  logic                  o_state_err;
  logic                  o_busy;

  modport master (
    output i_pwm_state,
    output i_timer_val,
    output i_timer_load,
    input  o_fnd_com,
    input  o_fnd_seg,
    input  o_state_err,
    input  o_busy
  );

  modport slave (
    input  i_pwm_state,
    input  i_timer_val,
    input  i_timer_load,
    output o_fnd_com,
    output o_fnd_seg,
    output o_state_err,
    output o_busy
  );
endinterface

// File: rtl/fnd_state_scanner.sv
// Multiplexed FND driver: state digit plus iterative BCD timer digits.
// Optional FND_DP_BLINK_EN lights digit-0 dp as a slow running indicator.
module fnd_state_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int STATE_W    = 3,
  parameter int NUM_STATES = 5,
  parameter int TIME_W     = 7,
  parameter int SCAN_DIV   = 100000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  fnd_state_scanner_if.slave bus
);

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [7:0] seg_dec(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  localparam int     WN  = TIME_W / 3 + 1;
  localparam int     WB  = 4 * WN;
  localparam int     DN  = NUM_DIGITS - 1;
  localparam int     DW  = 4 * DN;
  localparam int     EW  = (WB > DW) ? WB : DW;
  localparam int     CW  = $clog2(TIME_W + 1);
  localparam int     SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int     IW  = $clog2(NUM_DIGITS);
  localparam longint LIM = pow10(DN);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_st_e;

  bcd_st_e            st_q;
  bcd_st_e            st_d;
  logic               do_load;
  logic               do_step;
  logic               do_done;

  logic [STATE_W-1:0] held_q;
  logic               err_q;
  logic               st_ok;

  logic [TIME_W-1:0]  bin_q;
  logic [TIME_W-1:0]  sh_q;
  logic [WB-1:0]      work_q;
  logic [WB-1:0]      adj;
  logic [WB-1:0]      step;
  logic [CW-1:0]      cnt_q;
  logic [EW-1:0]      ext;
  logic               ovf;
  logic [DW-1:0]      disp_q;
  logic               busy_q;

  logic [SCW-1:0]        scan_q;
  logic [IW-1:0]         idx_q;
  logic                  tc;
  logic                  last;
  logic [NUM_DIGITS-1:0] com_q;
  logic [7:0]            seg_q;
  logic [7:0]            seg_d;
  logic [3:0]            nib;
  logic                  blank;
  logic                  zero_hi;
  logic                  dp0;

  // Compare in 32 bits so NUM_STATES == 2**STATE_W still works
  assign st_ok = 32'(bus.i_pwm_state) < 32'(NUM_STATES);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      held_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= ~st_ok;
      if (st_ok) held_q <= bus.i_pwm_state;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) st_q <= IDLE;
    else          st_q <= st_d;
  end

  always_comb begin
    st_d    = st_q;
    do_load = 1'b0;
    do_step = 1'b0;
    do_done = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (bus.i_timer_load) begin
          do_load = 1'b1;
          st_d    = SHIFT;
        end
      end
      SHIFT: begin
        do_step = 1'b1;
        if (cnt_q == CW'(TIME_W - 1)) st_d = DONE;
      end
      DONE: begin
        do_done = 1'b1;
        st_d    = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    adj = work_q;
    for (int i = 0; i < WN; i++) begin
      if (work_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
    step = {adj[WB-2:0], sh_q[TIME_W-1]};
  end

  assign ext = EW'(work_q);
  assign ovf = 64'(bin_q) >= 64'(LIM);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bin_q  <= '0;
      sh_q   <= '0;
      work_q <= '0;
      cnt_q  <= '0;
      disp_q <= '0;
      busy_q <= 1'b0;
    end else begin
      if (do_load) begin
        bin_q  <= bus.i_timer_val;
        sh_q   <= bus.i_timer_val;
        work_q <= '0;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end
      if (do_step) begin
        work_q <= step;
        sh_q   <= sh_q << 1;
        cnt_q  <= cnt_q + 1'b1;
      end
      if (do_done) begin
        disp_q <= ovf ? {DN{4'd9}} : ext[DW-1:0];
        busy_q <= 1'b0;
      end
    end
  end

  assign tc   = scan_q == SCW'(SCAN_DIV - 1);
  assign last = idx_q == IW'(NUM_DIGITS - 1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scan_q <= '0;
      idx_q  <= '0;
    end else if (tc) begin
      scan_q <= '0;
      idx_q  <= last ? '0 : idx_q + 1'b1;
    end else begin
      scan_q <= scan_q + 1'b1;
    end
  end

`ifdef FND_DP_BLINK_EN
  logic [7:0] frame_q;
  logic       blink_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_q <= '0;
      blink_q <= 1'b0;
    end else if (tc && last) begin
      frame_q <= frame_q + 1'b1;
      if (frame_q == 8'hFF) blink_q <= ~blink_q;
    end
  end

  assign dp0 = ~((held_q != '0) && blink_q);
`else
  assign dp0 = 1'b1;
`endif

  // A timer digit blanks when it and every digit above it are zero
  always_comb begin
    nib     = 4'hF;
    blank   = 1'b0;
    zero_hi = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (IW'(k) == idx_q) begin
        nib   = disp_q[4*(k-1) +: 4];
        blank = (k != 1) && zero_hi &&
                (disp_q[4*(k-1) +: 4] == 4'd0);
      end
      zero_hi = zero_hi &&
                (disp_q[4*(k-1) +: 4] == 4'd0);
    end
    if (idx_q == '0) begin
      seg_d = err_q ? 8'hBF : seg_dec(4'(held_q));
      seg_d = {dp0, seg_d[6:0]};
    end else if (blank) begin
      seg_d = 8'hFF;
    end else begin
      seg_d = seg_dec(nib);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      com_q <= '1;
      seg_q <= 8'hFF;
    end else begin
      com_q <= ~(NUM_DIGITS'(1) << idx_q);
      seg_q <= seg_d;
    end
  end

  assign bus.o_fnd_com   = com_q;
  assign bus.o_fnd_seg   = seg_q;
  assign bus.o_state_err = err_q;
  assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_fnd_state_scanner.sv
// Scoreboard bench: random state/timer stimulus, frame monitors
// on a 4-digit and a 2-digit (saturating) scanner.
module tb_fnd_state_scanner;

  localparam int SD = 4;
  localparam int TW = 7;

  typedef struct packed {
    logic [63:0] segs;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  exp_t q1[$];
  exp_t q2[$];

  logic [7:0] dec_tab [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  int held_m = 0;
  int disp_m = 0;

  always #5 clk = ~clk;

  fnd_state_scanner_if #(.NUM_DIGITS(4)) bus1 ();
  fnd_state_scanner_if #(.NUM_DIGITS(2)) bus2 ();

  assign bus2.i_pwm_state  = bus1.i_pwm_state;
  assign bus2.i_timer_val  = bus1.i_timer_val;
  assign bus2.i_timer_load = bus1.i_timer_load;

  fnd_state_scanner #(.NUM_DIGITS(4), .SCAN_DIV(SD)) dut1 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus1.slave)
  );

  fnd_state_scanner #(.NUM_DIGITS(2), .SCAN_DIV(SD)) dut2 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus2.slave)
  );

  function automatic logic [63:0] model(input int nd, input int st,
                                        input bit err, input int tv);
    logic [63:0] f;
    int lim;
    int p;
    int d;
    f = '1;
    lim = 10 ** (nd - 1);
    f[7:0] = err ? 8'hBF : dec_tab[st];
    for (int k = 1; k < nd; k++) begin
      p = 10 ** (k - 1);
      d = (tv >= lim) ? 9 : (tv / p) % 10;
      if (k == 1 || tv >= p) f[8*k +: 8] = dec_tab[d];
    end
    return f;
  endfunction

  function automatic int cold_idx(input logic [7:0] com);
    int n;
    int i;
    n = 0;
    i = -1;
    for (int b = 0; b < 8; b++) begin
      if (!com[b]) begin
        n++;
        i = b;
      end
    end
    return (n == 1) ? i : -1;
  endfunction

  task automatic capture(input int which, input int nd,
                         output logic [63:0] f, output logic err,
                         output bit ok);
    logic [7:0] com;
    logic [7:0] seg;
    int seen;
    int i;
    f = '1;
    err = 1'b0;
    ok = 1'b1;
    seen = 0;
    repeat (4 * SD * nd + 8) begin
      @(negedge clk);
      if (which == 1) begin
        com = {4'hF, bus1.o_fnd_com};
        seg = bus1.o_fnd_seg;
        err = bus1.o_state_err;
      end else begin
        com = {6'h3F, bus2.o_fnd_com};
        seg = bus2.o_fnd_seg;
        err = bus2.o_state_err;
      end
      i = cold_idx(com);
      if (i < 0 || i >= nd) begin
        ok = 1'b0;
      end else begin
        f[8*i +: 8] = seg;
        seen = seen | (1 << i);
      end
      if (seen == (1 << nd) - 1) break;
    end
    if (seen != (1 << nd) - 1) ok = 1'b0;
  endtask

  task automatic monitor(input int which, input int nd);
    exp_t e;
    logic [63:0] f;
    logic err;
    bit ok;
    forever begin
      @(negedge clk);
      if ((which == 1 && q1.size() != 0) ||
          (which == 2 && q2.size() != 0)) begin
        e = (which == 1) ? q1[0] : q2[0];
        capture(which, nd, f, err, ok);
        checks++;
        if (!ok || f != e.segs) begin
          failures++;
          $display("FAIL frame dut%0d: got %h ok=%0d want %h",
                   which, f, ok, e.segs);
        end
        checks++;
        if (err != e.err) begin
          failures++;
          $display("FAIL state_err dut%0d: got %0b want %0b",
                   which, err, e.err);
        end
        if (which == 1) void'(q1.pop_front());
        else            void'(q2.pop_front());
      end
    end
  endtask

  initial monitor(1, 4);
  initial monitor(2, 2);

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic txn(input int st, input int tv,
                     input bit dbl, input int tv2);
    int n;
    bit err;
    bus1.i_pwm_state = 3'(st);
    @(negedge clk);
    bus1.i_timer_val  = 7'(tv);
    bus1.i_timer_load = 1'b1;
    @(negedge clk);
    bus1.i_timer_load = 1'b0;
    n = 0;
    repeat (40) begin
      if (!bus1.o_busy) break;
      n++;
      if (dbl && n == 2) begin
        bus1.i_timer_val  = 7'(tv2);
        bus1.i_timer_load = 1'b1;
      end else begin
        bus1.i_timer_load = 1'b0;
      end
      @(negedge clk);
    end
    bus1.i_timer_load = 1'b0;
    chk("busy_len", n, TW + 1);
    err = st >= 5;
    if (!err) held_m = st;
    disp_m = tv;
    repeat (3) @(negedge clk);
    q1.push_back('{model(4, held_m, err, disp_m), err});
    q2.push_back('{model(2, held_m, err, disp_m), err});
    n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_timeout: got pending want empty");
      q1.delete();
      q2.delete();
    end
  endtask

  initial begin
    int n;
    bus1.i_pwm_state  = '0;
    bus1.i_timer_val  = '0;
    bus1.i_timer_load = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_com", bus1.o_fnd_com, 4'hF);
    chk("rst_seg", bus1.o_fnd_seg, 8'hFF);
    chk("rst_busy", bus1.o_busy, 0);
    chk("rst_err", bus1.o_state_err, 0);
    rst_n = 1'b1;

    txn(3, 87, 0, 0);
    txn(6, 5, 0, 0);
    txn(2, 0, 0, 0);
    txn(1, 100, 0, 0);
    txn(7, 99, 0, 0);
    txn(0, 10, 0, 0);
    txn(4, 127, 1, 3);
    txn(5, 100, 1, 7);

    // Asynchronous abort in the middle of a conversion and scan
    bus1.i_timer_val  = 7'd42;
    bus1.i_timer_load = 1'b1;
    @(negedge clk);
    bus1.i_timer_load = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_com", bus1.o_fnd_com, 4'hF);
    chk("arst_seg", bus1.o_fnd_seg, 8'hFF);
    chk("arst_busy", bus1.o_busy, 0);
    @(negedge clk);
    bus1.i_pwm_state = 3'd0;
    rst_n = 1'b1;
    n = 0;
    while (bus1.o_fnd_com == 4'hF && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("scan_first", bus1.o_fnd_com, 4'b1110);
    repeat (SD) @(negedge clk);
    chk("scan_next", bus1.o_fnd_com, 4'b1101);
    repeat (3 * SD) @(negedge clk);
    chk("scan_wrap", bus1.o_fnd_com, 4'b1110);
    held_m = 0;
    disp_m = 0;
    q1.push_back('{model(4, 0, 0, 0), 1'b0});
    q2.push_back('{model(2, 0, 0, 0), 1'b0});
    n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      failures++;
      $display("FAIL post_reset_timeout: got pending want empty");
      q1.delete();
      q2.delete();
    end

    for (int t = 0; t < 14; t++) begin
      txn($urandom_range(0, 7), $urandom_range(0, 127),
          ($urandom_range(0, 2) == 0), $urandom_range(0, 127));
    end

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
